// File: rtl/clk_freq_meter_pkg.sv
// Shared constants and state encoding for the clock frequency meter.
package clk_freq_meter_pkg;

    localparam int unsigned FMETER_TIMEOUT = 32'd100_000_000;

    typedef enum logic [1:0] {
        FM_IDLE    = 2'd0,
        FM_ARM     = 2'd1,
        FM_MEASURE = 2'd2
    } fm_state_t;

endpackage

// File: rtl/clk_freq_meter_sync_edge_detect.sv
// Multi-stage synchroniser for an asynchronous input plus one history flop
// for rising/falling edge detection in the receiving clock domain.
module clk_freq_meter_sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    // Fewer than two stages would not give metastability time to settle.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/clk_freq_meter.sv
// Measures period and high time of a slow asynchronous signal in cycles of
// out_clk, with a sticky timeout when the signal stops toggling.
module clk_freq_meter
    import clk_freq_meter_pkg::*;
#(
    parameter int          CNT_W       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = FMETER_TIMEOUT
) (
    input  logic             out_clk,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             timeout,
    output logic             measuring
);

    fm_state_t        r_state;
    fm_state_t        w_next_state;
    logic [CNT_W-1:0] r_run_cnt;
    logic [CNT_W-1:0] r_hi_cnt;
    logic             w_rise;
    logic             w_fall;
    logic             w_level_unused;
    logic             w_active;
    logic             w_timeout_hit;

    clk_freq_meter_sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (out_clk),
        .i_rst_n (reset_n),
        .i_async (sig_in),
        .o_level (w_level_unused),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_active  = (r_state != FM_IDLE);
    assign measuring = w_active;

    // Zero-extend both sides so a TIMEOUT wider than the counter never matches.
    assign w_timeout_hit = ({32'd0, r_run_cnt} >= {{CNT_W{1'b0}}, TIMEOUT});

    always_ff @(posedge out_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FM_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FM_IDLE: begin
                if (enable) w_next_state = FM_ARM;
            end
            FM_ARM: begin
                if (!enable)     w_next_state = FM_IDLE;
                else if (w_rise) w_next_state = FM_MEASURE;
            end
            FM_MEASURE: begin
                if (!enable)                       w_next_state = FM_IDLE;
                else if (!w_rise && w_timeout_hit) w_next_state = FM_ARM;
            end
            default: w_next_state = FM_IDLE;
        endcase
    end

    // Disable has priority over a coincident rise; the first rise after arming
    // only restarts the count, so a partial period is never reported.
    always_ff @(posedge out_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run_cnt    <= '0;
            r_hi_cnt     <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (!w_active) begin
                if (enable) r_run_cnt <= '0;
            end else if (enable) begin
                if (w_rise) begin
                    r_run_cnt <= CNT_W'(1);
                    if (r_state == FM_ARM) begin
                        timeout <= 1'b0;
                    end else begin
                        period       <= r_run_cnt;
                        high_time    <= r_hi_cnt;
                        period_valid <= 1'b1;
                    end
                end else if (w_timeout_hit) begin
                    timeout   <= 1'b1;
                    r_run_cnt <= '0;
                end else if (r_run_cnt != '1) begin
                    r_run_cnt <= r_run_cnt + CNT_W'(1);
                end
                if (w_fall) r_hi_cnt <= r_run_cnt;
            end
        end
    end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Self-checking bench for clk_freq_meter: table-driven waveforms with a
// scoreboard of expected results, plus timeout/enable/reset/saturation cases.
module tb_clk_freq_meter;

    typedef struct {
        int hi;
        int lo;
        int n;
        int expPeriod;
        int expHigh;
    } vec_t;

    typedef struct {
        int period;
        int high;
        int gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        sigIn = 1'b0;
    logic        enable = 1'b0;
    logic        sigIn2 = 1'b0;
    logic        enable2 = 1'b0;
    logic [31:0] period;
    logic [31:0] highTime;
    logic        periodValid;
    logic        timeout;
    logic        measuring;
    logic [3:0]  period2;
    logic [3:0]  highTime2;
    logic        periodValid2;
    logic        timeout2;
    logic        measuring2;

    int   compared = 0;
    int   mismatched = 0;
    exp_t q1[$];
    exp_t q2[$];
    vec_t vecs[5];
    int   waitCnt;

    clk_freq_meter #(.CNT_W(32), .SYNC_STAGES(2), .TIMEOUT(50)) dut (
        .out_clk      (clk),
        .reset_n      (reset_n),
        .sig_in       (sigIn),
        .enable       (enable),
        .period       (period),
        .high_time    (highTime),
        .period_valid (periodValid),
        .timeout      (timeout),
        .measuring    (measuring)
    );

    clk_freq_meter #(.CNT_W(4), .SYNC_STAGES(2), .TIMEOUT(100)) dutSat (
        .out_clk      (clk),
        .reset_n      (reset_n),
        .sig_in       (sigIn2),
        .enable       (enable2),
        .period       (period2),
        .high_time    (highTime2),
        .period_valid (periodValid2),
        .timeout      (timeout2),
        .measuring    (measuring2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard for the 32-bit instance: every valid pulse must match the next expectation.
    int   cyc1 = 0;
    int   last1 = 0;
    logic prev1 = 1'b0;
    exp_t e1;
    always @(negedge clk) begin
        cyc1++;
        if (periodValid) begin
            checkOutput("valid_width", prev1, 0);
            checkOutput("valid_expected", q1.size() > 0, 1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                checkOutput("period", period, e1.period);
                checkOutput("high_time", highTime, e1.high);
                if (e1.gap >= 0) checkOutput("valid_gap", cyc1 - last1, e1.gap);
            end
            last1 = cyc1;
        end
        prev1 = periodValid;
    end

    int   cyc2 = 0;
    int   last2 = 0;
    exp_t e2;
    always @(negedge clk) begin
        cyc2++;
        if (periodValid2) begin
            checkOutput("sat_valid_expected", q2.size() > 0, 1);
            if (q2.size() > 0) begin
                e2 = q2.pop_front();
                checkOutput("sat_period", period2, e2.period);
                checkOutput("sat_high_time", highTime2, e2.high);
                if (e2.gap >= 0) checkOutput("sat_valid_gap", cyc2 - last2, e2.gap);
            end
            last2 = cyc2;
        end
    end

    task automatic applyStimulus(input vec_t v);
        enable = 1'b1;
        sigIn  = 1'b0;
        repeat (6) tick();
        for (int p = 0; p < v.n; p++) begin
            if (p > 0) q1.push_back('{v.expPeriod, v.expHigh, (p == 1) ? -1 : v.expPeriod});
            sigIn = 1'b1;
            repeat (v.hi) tick();
            sigIn = 1'b0;
            repeat (v.lo) tick();
        end
        q1.push_back('{v.expPeriod, v.expHigh, (v.n == 1) ? -1 : v.expPeriod});
        sigIn = 1'b1;
        repeat (8) tick();
        checkOutput("measuring_on", measuring, 1);
        checkOutput("no_timeout", timeout, 0);
        checkOutput("q1_drained", q1.size(), 0);
        enable = 1'b0;
        sigIn  = 1'b0;
        repeat (4) tick();
        checkOutput("measuring_off", measuring, 0);
    endtask

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{4, 4, 3, 8, 4};
        vecs[1] = '{3, 7, 3, 10, 3};
        vecs[2] = '{1, 1, 3, 2, 1};
        vecs[3] = '{5, 2, 2, 7, 5};
        vecs[4] = '{6, 9, 2, 15, 6};

        #1 reset_n = 1'b0;
        #2;
        checkOutput("rst_period", period, 0);
        checkOutput("rst_high_time", highTime, 0);
        checkOutput("rst_valid", periodValid, 0);
        checkOutput("rst_timeout", timeout, 0);
        checkOutput("rst_measuring", measuring, 0);
        checkOutput("rst_measuring_sat", measuring2, 0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        tick();

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Timeout: two full periods, then the signal stops.
        enable = 1'b1;
        sigIn  = 1'b0;
        repeat (6) tick();
        sigIn = 1'b1; repeat (4) tick(); sigIn = 1'b0; repeat (4) tick();
        q1.push_back('{8, 4, -1});
        sigIn = 1'b1; repeat (4) tick(); sigIn = 1'b0; repeat (4) tick();
        q1.push_back('{8, 4, 8});
        sigIn = 1'b1;
        fork
            begin
                repeat (4) tick();
                sigIn = 1'b0;
            end
            begin
                waitCnt = 0;
                do begin @(negedge clk); waitCnt++; end while (!periodValid && waitCnt < 20);
                checkOutput("valid_before_stop", periodValid, 1);
                waitCnt = 0;
                do begin @(negedge clk); waitCnt++; end while (!timeout && waitCnt < 200);
                checkOutput("timeout_delay", waitCnt, 50);
            end
        join
        checkOutput("timeout_set", timeout, 1);
        checkOutput("timeout_period_hold", period, 8);
        checkOutput("timeout_high_hold", highTime, 4);
        checkOutput("timeout_rearmed", measuring, 1);
        fork
            begin
                tick();
                sigIn = 1'b1; repeat (4) tick(); sigIn = 1'b0; repeat (4) tick();
                q1.push_back('{8, 4, -1});
                sigIn = 1'b1; repeat (4) tick(); sigIn = 1'b0; repeat (4) tick();
            end
            begin
                waitCnt = 0;
                do begin @(negedge clk); waitCnt++; end while (timeout && waitCnt < 30);
                checkOutput("timeout_cleared", timeout, 0);
                waitCnt = 0;
                do begin @(negedge clk); waitCnt++; end while (!periodValid && waitCnt < 30);
                checkOutput("restart_valid_delay", waitCnt, 8);
            end
        join
        enable = 1'b0;
        repeat (4) tick();
        checkOutput("q1_after_timeout", q1.size(), 0);

        // Enable dropped mid-period for 5 cycles.
        enable = 1'b1;
        sigIn  = 1'b0;
        repeat (6) tick();
        sigIn = 1'b1; repeat (4) tick(); sigIn = 1'b0; repeat (4) tick();
        q1.push_back('{8, 4, -1});
        sigIn = 1'b1; repeat (4) tick(); sigIn = 1'b0; repeat (2) tick();
        enable = 1'b0;
        repeat (2) tick();
        checkOutput("disable_measuring", measuring, 0);
        checkOutput("disable_period_hold", period, 8);
        checkOutput("disable_high_hold", highTime, 4);
        repeat (3) tick();
        enable = 1'b1;
        repeat (6) tick();
        checkOutput("reenable_measuring", measuring, 1);
        sigIn = 1'b1; repeat (4) tick(); sigIn = 1'b0; repeat (4) tick();
        q1.push_back('{8, 4, -1});
        sigIn = 1'b1;
        repeat (8) tick();
        checkOutput("q1_after_reenable", q1.size(), 0);
        enable = 1'b0;
        sigIn  = 1'b0;
        repeat (4) tick();

        // Asynchronous reset in the middle of a high phase.
        enable = 1'b1;
        repeat (6) tick();
        sigIn = 1'b1; repeat (4) tick(); sigIn = 1'b0; repeat (4) tick();
        q1.push_back('{8, 4, -1});
        sigIn = 1'b1;
        repeat (5) tick();
        checkOutput("pre_reset_period", period, 8);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("midrst_period", period, 0);
        checkOutput("midrst_high_time", highTime, 0);
        checkOutput("midrst_valid", periodValid, 0);
        checkOutput("midrst_timeout", timeout, 0);
        checkOutput("midrst_measuring", measuring, 0);
        sigIn  = 1'b0;
        enable = 1'b0;
        @(posedge clk);
        #4 reset_n = 1'b1;
        tick();
        checkOutput("post_rst_period", period, 0);
        applyStimulus(vecs[1]);

        // Narrow counter with an unreachable timeout saturates instead of wrapping.
        enable2 = 1'b1;
        sigIn2  = 1'b0;
        repeat (6) tick();
        for (int p = 0; p < 3; p++) begin
            if (p > 0) q2.push_back('{15, 15, (p == 1) ? -1 : 40});
            sigIn2 = 1'b1; repeat (20) tick();
            sigIn2 = 1'b0; repeat (20) tick();
        end
        q2.push_back('{15, 15, 40});
        sigIn2 = 1'b1;
        repeat (8) tick();
        checkOutput("sat_q_drained", q2.size(), 0);
        checkOutput("sat_no_timeout", timeout2, 0);
        checkOutput("sat_measuring", measuring2, 1);
        enable2 = 1'b0;
        sigIn2  = 1'b0;
        repeat (4) tick();

        checkOutput("q1_final", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/clk_freq_meter.md
Name: clk_freq_meter

Overview:
- Measuring counterpart of the clock divider: takes a slow, asynchronous square wave such as a divided clock or an external tick.
- Reports its period and high time, counted in cycles of the fast board clock.
- Provides on-board self-check of the divider output and gives the CPU a measured-frequency status word.
- Single clock domain (out_clk); the input signal is synchronised internally.

Parameters:
- CNT_W, 32, width of all cycle counters and result registers.
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser (minimum 2).
- TIMEOUT, 32'd100_000_000, out_clk cycles without a rising edge before timeout is flagged.

Ports:
- out_clk  input  1  fast board clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- sig_in  input  1  asynchronous signal under measurement.
- enable  input  1  measurement enable; low forces IDLE.
- period  output  CNT_W  out_clk cycles between the last two sig_in rising edges.
- high_time  output  CNT_W  out_clk cycles sig_in was high within that period.
- period_valid  output  1  one-cycle pulse when period/high_time update.
- timeout  output  1  sticky flag: no rising edge within TIMEOUT cycles.
- measuring  output  1  high while in ARM or MEASURE.

Behaviour:
- Reset (async, reset_n=0):
  - period=0, high_time=0, period_valid=0, timeout=0, measuring=0.
  - Synchroniser flops cleared; run_cnt=0; hi_cnt=0; state=IDLE.
- Synchroniser and edge detect:
  - sig_in passes through SYNC_STAGES flops, then one extra flop for edge detect.
  - rise = sync & ~prev; fall = ~sync & prev.
  - A sig_in edge is detected SYNC_STAGES+1 cycles after it occurs. Latency is constant, so period is unaffected.
- run_cnt:
  - Loaded with 1 in the cycle rise is detected; otherwise increments by 1, saturating at all-ones (never wraps).
  - At a rise-detect cycle, run_cnt therefore equals the number of cycles since the previous rise detect.
- hi_cnt: on fall detect, hi_cnt <= run_cnt, i.e. cycles from rise to fall.
- States:
  - IDLE: measuring=0; counters hold. enable=1 -> ARM.
  - ARM: waiting for the first rise; no result produced. On rise -> MEASURE, run_cnt<=1, timeout cleared.
  - MEASURE: on rise -> period<=run_cnt, high_time<=hi_cnt, period_valid=1 in the next cycle (registered, exactly one cycle), run_cnt<=1; stay in MEASURE.
- Timeout: in ARM or MEASURE, if run_cnt reaches TIMEOUT without a rise -> timeout=1, state->ARM. period and high_time hold their last values.
- timeout clears only on the next rise detected in ARM, or on reset.
- enable deasserted in any state -> IDLE next cycle. No period_valid is generated; outputs hold; timeout holds.
- Re-enable always goes through ARM. The first partial period is never reported.
- Simultaneous rise and enable falling in the same cycle: enable wins; no update.
- sig_in constant high or constant low: no rise, leads to timeout. Glitches shorter than one out_clk cycle may be missed; this is accepted.
- Minimum measurable period is 2 cycles. A fall seen before any rise in MEASURE is impossible by construction.
- Reset mid-measurement returns everything to reset values immediately, with no period_valid.

Decomposition:
- Shared constants in define.v: `FMETER_TIMEOUT` default, and state encodings `FM_IDLE`=2'd0, `FM_ARM`=2'd1, `FM_MEASURE`=2'd2.
- One sub-module: sync_edge_detect. It contains the parameterised synchroniser plus the prev flop, with outputs sync_level, rise and fall. It is reused for any other asynchronous inputs (buttons, external ticks).

Test Plan:
1. Drive sig_in from clk_divider with `COUNTER_MAX`=4, enable=1 -> after arming, period_valid pulses every 8 cycles with period=8, high_time=4.
2. sig_in 3 cycles high / 7 cycles low -> period=10, high_time=3. Pulses are 10 cycles apart, and the first pulse occurs at the second detected rise.
3. TIMEOUT=50; stop sig_in low after two periods -> timeout=1 exactly 50 cycles after the last rise detect, period holds 8. Restart sig_in -> timeout clears on the first rise, and the next period_valid arrives one full period later.
4. Deassert enable mid-period for 5 cycles, then reassert -> no period_valid during or immediately after. The first new valid comes after two rises, with the correct period.
5. Assert reset_n=0 asynchronously mid-period (not clock-aligned) -> all outputs 0 immediately. After release, behaviour matches a fresh start.
6. TIMEOUT larger than 2^CNT_W-1 with CNT_W=4 and a 40-cycle period -> run_cnt saturates at 15, and period reports 15 (saturation, no wrap).
